// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: the hex glyph table
// and the blank/off codes (all active-low).
package seg_pkg;
  localparam int NUM_DIG = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Bit order g..a; index is the hex nibble
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with double-buffered value and
// frame-aligned commit. SEG_SCAN_DP_EN adds the per-digit decimal point input.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] hex_val,
  input  logic        load,
  input  logic [3:0]  digit_en,
`ifdef SEG_SCAN_DP_EN
  input  logic [3:0]  dp_in,
`endif
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        busy,
  output logic        frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0]             cnt;
  logic [1:0]                idx;
  logic [NUM_DIG-1:0][3:0]   pending, shadow;
  logic [NUM_DIG-1:0][6:0]   dig_seg;
  logic                      tick, wrap, wrap_d, dp_nxt;

  assign tick = (cnt == CW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 2'd1;
    end
  end

  // Shadow only changes on the frame wrap so a frame never mixes two values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      shadow  <= '0;
      busy    <= 1'b0;
    end else if (load && wrap) begin
      shadow  <= hex_val;
      busy    <= 1'b0;
    end else if (load) begin
      pending <= hex_val;
      busy    <= 1'b1;
    end else if (wrap && busy) begin
      shadow  <= pending;
      busy    <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dec
    seg_hex_decode u_dec (.nib(shadow[g]), .seg(dig_seg[g]));
  end

`ifdef SEG_SCAN_DP_EN
  assign dp_nxt = ~dp_in[idx];
`else
  assign dp_nxt = 1'b1;
`endif

  // frame_done is delayed twice so it lines up with the first digit-0 output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      wrap_d     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wrap_d     <= wrap;
      frame_done <= wrap_d;
      if (digit_en[idx]) begin
        an  <= ~(4'b0001 << idx);
        seg <= dig_seg[idx];
        dp  <= dp_nxt;
      end else begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver at REFRESH_DIV=4: cycle scoreboard plus a table of
// display vectors and hand-written frame-boundary sequences.
module tb_seg_scan_driver;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [15:0] hex_val = '0;
  logic [3:0]  digit_en = 4'hF;
`ifdef SEG_SCAN_DP_EN
  logic [3:0]  dp_in = 4'h0;
`endif
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp, busy, frame_done;

  seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .hex_val(hex_val), .load(load), .digit_en(digit_en),
`ifdef SEG_SCAN_DP_EN
    .dp_in(dp_in),
`endif
    .seg(seg), .an(an), .dp(dp), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [15:0]      hex;
    logic [3:0]       en;
    logic [3:0][6:0]  eseg;
    logic [3:0][3:0]  ean;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[4];

  int          checks = 0, errors = 0;
  int          n = 0;            // rising edges since reset release
  logic [15:0] m_shadow = '0, m_pend = '0;
  logic        m_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp, n);
    end
  endtask

  // Predict the outputs after the coming edge, advance one clock, compare.
  task automatic step();
    exp_t e;
    int   slot;
    logic wrap;
    slot   = (n / DIV) % 4;
    wrap   = (n % FRAME) == FRAME - 1;
    e.an   = 4'b1111;
    if (digit_en[slot]) e.an[slot] = 1'b0;
    e.seg  = digit_en[slot] ? DEC[m_shadow[4*slot +: 4]] : 7'h7F;
    e.dp   = 1'b1;
    e.fd   = (n > 0) && (n % FRAME == 0);
    if (load) begin
      if (wrap) begin m_shadow = hex_val; m_busy = 1'b0; end
      else begin m_pend = hex_val; m_busy = 1'b1; end
    end else if (wrap && m_busy) begin
      m_shadow = m_pend;
      m_busy   = 1'b0;
    end
    e.busy = m_busy;
    sbq.push_back(e);
    @(posedge clk); #1;
    n++;
    e = sbq.pop_front();
    chk("sb_an", an, e.an);
    chk("sb_seg", seg, e.seg);
    chk("sb_dp", dp, e.dp);
    chk("sb_busy", busy, e.busy);
    chk("sb_frame_done", frame_done, e.fd);
  endtask

  task automatic run_to(input int ph);
    while (n % FRAME != ph) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"}, an, 4'b1111);
    chk({tag, "_seg"}, seg, 7'h7F);
    chk({tag, "_dp"}, dp, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
  endtask

  initial begin
    int ones;
    tbl[0] = '{hex: 16'h12AF, en: 4'hF,
               eseg: {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110},
               ean:  {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    tbl[1] = '{hex: 16'h3456, en: 4'hF,
               eseg: {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010},
               ean:  {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    tbl[2] = '{hex: 16'hB987, en: 4'b0101,
               eseg: {7'h7F, 7'b0010000, 7'h7F, 7'b1111000},
               ean:  {4'b1111, 4'b1011, 4'b1111, 4'b1110}};
    tbl[3] = '{hex: 16'hEDC0, en: 4'b1110,
               eseg: {7'b0000110, 7'b0100001, 7'b1000110, 7'h7F},
               ean:  {4'b0111, 4'b1011, 4'b1101, 4'b1111}};

    #12;
    chk_reset_vals("reset");
    #6 rst = 1'b0;

    // Scan after reset: blank-zero value on every digit in turn
    repeat (FRAME) step();

    foreach (tbl[i]) begin
      digit_en = tbl[i].en;
      run_to(5);
      hex_val = tbl[i].hex;
      load    = 1'b1;
      step();
      load    = 1'b0;
      chk("tbl_busy_pending", busy, 1'b1);
      run_to(0);
      for (int k = 0; k < FRAME; k++) begin
        step();
        chk($sformatf("tbl%0d_seg_d%0d", i, k / DIV), seg, tbl[i].eseg[k / DIV]);
        chk($sformatf("tbl%0d_an_d%0d", i, k / DIV), an, tbl[i].ean[k / DIV]);
      end
    end

    // Two loads in one frame: only the last is ever shown
    digit_en = 4'hF;
    run_to(3);
    hex_val = 16'h1111; load = 1'b1; step(); load = 1'b0;
    step(); step();
    hex_val = 16'h2222; load = 1'b1; step(); load = 1'b0;
    run_to(0);
    ones = 0;
    repeat (FRAME) begin
      step();
      if (seg == 7'b1111001) ones++;
    end
    chk("no_stale_1111", ones, 0);

    // Load on the wrap tick bypasses pending
    run_to(FRAME - 1);
    hex_val = 16'h0008; load = 1'b1; step(); load = 1'b0;
    chk("wrap_load_busy", busy, 1'b0);
    step();
    chk("wrap_load_seg", seg, 7'b0000000);
    chk("wrap_load_an", an, 4'b1110);
    repeat (FRAME) step();

    // Reset during digit 2 with a value pending
    run_to(2 * DIV + 1);
    hex_val = 16'hABCD; load = 1'b1; step(); load = 1'b0;
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(posedge clk); #3;
    rst = 1'b0;
    n = 0; m_shadow = '0; m_pend = '0; m_busy = 1'b0;
    step();
    chk("post_rst_an", an, 4'b1110);
    chk("post_rst_seg", seg, 7'b1000000);
    chk("post_rst_busy", busy, 1'b0);
    repeat (2 * FRAME) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
